// File: rtl/game_pkg.sv
// Shared game definitions: action codes, player position codes and button indices
// used by the action encoder and the player modules.
package game_pkg;

    typedef enum logic [2:0] {
        ACT_KICK   = 3'b000,
        ACT_PUNCH  = 3'b001,
        ACT_AWAIT  = 3'b010,
        ACT_JUMP   = 3'b011,
        ACT_LEFT1  = 3'b100,
        ACT_LEFT2  = 3'b101,
        ACT_RIGHT1 = 3'b110,
        ACT_RIGHT2 = 3'b111
    } action_t;

    typedef enum logic [1:0] {
        POS_LEFT   = 2'd0,
        POS_CENTER = 2'd1,
        POS_RIGHT  = 2'd2,
        POS_AIR    = 2'd3
    } position_t;

    localparam int NUM_BTN   = 5;
    localparam int BTN_KICK  = 0;
    localparam int BTN_PUNCH = 1;
    localparam int BTN_JUMP  = 2;
    localparam int BTN_LEFT  = 3;
    localparam int BTN_RIGHT = 4;

    // Movement alternates step 1 / step 2 while the same direction is repeated.
    function automatic action_t next_move(input action_t prev, input logic go_right);
        action_t result;
        if (go_right) begin
            if (prev == ACT_RIGHT1) result = ACT_RIGHT2;
            else                    result = ACT_RIGHT1;
        end else begin
            if (prev == ACT_LEFT1)  result = ACT_LEFT2;
            else                    result = ACT_LEFT1;
        end
        return result;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, counter-based debouncer and registered rising-edge pulse
// for one raw asynchronous button.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          rise_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            rise_reg  <= 1'b0;
            // cnt_reg counts samples already seen that disagree with the accepted level
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CW'(DEBOUNCE_CYC - 1)) begin
                level_reg <= sync2_reg;
                rise_reg  <= sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/action_encoder.sv
// Turns five debounced player buttons into one encoded action per game tick,
// with attack cooldown, edge-triggered jump and alternating movement steps.
module action_encoder
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYC   = 4,
    parameter int TICK_DIV       = 8,
    parameter int COOLDOWN_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_kick,
    input  logic       btn_punch,
    input  logic       btn_jump,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [2:0] action,
    output logic       action_valid,
    output logic       busy
);

    localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CDW = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] rise;

    logic [TW-1:0]  tick_cnt_reg;
    logic [CDW-1:0] cooldown_reg;
    logic [CDW-1:0] cooldown_next;
    action_t        action_reg;
    action_t        action_next;
    logic           action_valid_reg;
    logic           jump_pending_reg;
    logic           tick;
    logic           kick_ok;
    logic           punch_ok;
    logic           left_only;
    logic           right_only;
    logic           unused_rise;

    assign btn_raw[BTN_KICK]  = btn_kick;
    assign btn_raw[BTN_PUNCH] = btn_punch;
    assign btn_raw[BTN_JUMP]  = btn_jump;
    assign btn_raw[BTN_LEFT]  = btn_left;
    assign btn_raw[BTN_RIGHT] = btn_right;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYC(DEBOUNCE_CYC)
            ) u_debounce (
                .clk  (clk),
                .rst  (rst),
                .btn  (btn_raw[gi]),
                .level(level[gi]),
                .rise (rise[gi])
            );
        end
    endgenerate

    // Only jump is edge-triggered; the jump level itself is never consulted.
    assign unused_rise = ^{rise[BTN_KICK], rise[BTN_PUNCH], rise[BTN_LEFT],
                           rise[BTN_RIGHT], level[BTN_JUMP]};

    assign tick = (tick_cnt_reg == TW'(TICK_DIV - 1));

    always_comb begin
        kick_ok       = level[BTN_KICK]  && (cooldown_reg == '0);
        punch_ok      = level[BTN_PUNCH] && (cooldown_reg == '0);
        left_only     = level[BTN_LEFT]  && !level[BTN_RIGHT];
        right_only    = level[BTN_RIGHT] && !level[BTN_LEFT];
        action_next   = ACT_AWAIT;
        cooldown_next = cooldown_reg;

        if (kick_ok)               action_next = ACT_KICK;
        else if (punch_ok)         action_next = ACT_PUNCH;
        else if (jump_pending_reg) action_next = ACT_JUMP;
        else if (right_only)       action_next = next_move(action_reg, 1'b1);
        else if (left_only)        action_next = next_move(action_reg, 1'b0);

        if (kick_ok || punch_ok)     cooldown_next = CDW'(COOLDOWN_TICKS);
        else if (cooldown_reg != '0) cooldown_next = cooldown_reg - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_reg     <= '0;
            cooldown_reg     <= '0;
            action_reg       <= ACT_AWAIT;
            action_valid_reg <= 1'b0;
            jump_pending_reg <= 1'b0;
        end else begin
            action_valid_reg <= tick;
            if (tick) begin
                tick_cnt_reg <= '0;
                action_reg   <= action_next;
                cooldown_reg <= cooldown_next;
            end else begin
                tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
            // A fresh edge outranks the clear from a tick that issues the jump.
            if (rise[BTN_JUMP]) begin
                jump_pending_reg <= 1'b1;
            end else if (tick && (action_next == ACT_JUMP)) begin
                jump_pending_reg <= 1'b0;
            end
        end
    end

    assign action       = action_reg;
    assign action_valid = action_valid_reg;
    assign busy         = (cooldown_reg != '0);

endmodule

// File: doc/action_encoder.md
ACTION_ENCODER -- requirements
Module: action_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 4: consecutive equal synchronized samples required to accept a new button level.
REQ-002 Parameter TICK_DIV, default 8: clk cycles per game tick (≥2).
REQ-003 Parameter COOLDOWN_TICKS, default 2: ticks after kick or punch during which attacks are refused.
REQ-004 clk  in  1  single system clock; all logic is on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 btn_kick, btn_punch, btn_jump, btn_left, btn_right  in  1 each  raw asynchronous player buttons, active-high.
REQ-007 action  out  3  encoded action for the current tick: kick 000, punch 001, await 010, jump 011, left1 100, left2 101, right1 110, right2 111.
REQ-008 action_valid  out  1  one-cycle pulse marking the cycle in which action takes a new value.
REQ-009 busy  out  1  high while the attack cooldown is non-zero.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer, then a debouncer that updates its debounced level only after DEBOUNCE_CYC consecutive equal synchronized samples.
REQ-011 The tick counter SHALL count 0..TICK_DIV-1 and wrap; the tick event SHALL occur in the cycle the count equals TICK_DIV-1.
REQ-012 On a tick, action SHALL register the decoded value and action_valid SHALL be 1 for exactly that cycle; otherwise action holds and action_valid is 0.
REQ-013 Decode priority at the tick: kick, punch, jump, movement, await.
REQ-014 Kick or punch SHALL be selected only if its debounced level is high and cooldown = 0; when refused, decode SHALL fall through to the next priority.
REQ-015 Issuing kick or punch SHALL load cooldown with COOLDOWN_TICKS; otherwise cooldown SHALL decrement by 1 per tick, saturating at 0.
REQ-016 Jump SHALL be edge-triggered: a debounced rising edge sets jump_pending; a tick selecting jump clears it; a held button yields one jump only.
REQ-017 jump_pending set by an edge and cleared by a tick in the same cycle SHALL remain set (new edge wins).
REQ-018 If jump_pending is set but the tick selects kick or punch, jump_pending SHALL be kept for the next tick.
REQ-019 Movement SHALL be considered only when exactly one of left/right is debounced-high; both high or neither SHALL produce await.
REQ-020 Right on a tick SHALL emit right2 if the previous tick's action was right1, else right1; left SHALL follow the same rule with left1/left2.
REQ-021 Any non-movement tick, or a direction change, SHALL restart the alternation at left1/right1.
REQ-022 busy SHALL equal (cooldown != 0), combinationally from the cooldown register.

Reset
REQ-023 During rst: action = 010 (await), action_valid = 0, busy = 0, cooldown = 0, tick counter = 0, jump_pending = 0, debounced levels = 0, debounce counters = 0, synchronizers = 0.
REQ-024 Reset asserted mid-tick SHALL abandon the pending decision; the first tick after release SHALL occur TICK_DIV cycles after rst deasserts.
REQ-025 A button held through reset SHALL be re-debounced from zero and SHALL count as a rising edge for jump.

Structure
REQ-026 Action codes (kick..right2), a 3-bit action typedef and player position codes SHALL live in the shared package game_pkg, used by this block and the player modules.
REQ-027 A sub-module btn_debounce (synchronizer + debounce counter + rising-edge output, DEBOUNCE_CYC parameter) SHALL be instantiated five times.

Verification (TICK_DIV=8, DEBOUNCE_CYC=4, COOLDOWN_TICKS=2)
REQ-028 rst 3 cycles, no buttons -> action=010, action_valid=0 until cycle 8 after release, then a pulse every 8 cycles with action=010.
REQ-029 btn_right held 4 ticks -> actions 110,111,110,111; release for 1 tick -> 010; press again -> 110.
REQ-030 btn_kick held 5 ticks -> 000, then a refused attack with right held gives 110,111, then 000 again on tick 4; busy high for exactly 2 ticks after each kick.
REQ-031 btn_jump held 3 ticks -> 011 then 010,010; 2-cycle glitch on btn_kick (shorter than DEBOUNCE_CYC) -> no 000 emitted.
REQ-032 btn_left and btn_right held together -> 010 every tick; add btn_punch with cooldown 0 -> 001.
REQ-033 rst asserted 3 cycles before a tick while kick is held -> no action_valid that cycle, action=010, cooldown=0; first post-reset tick with kick held -> 000.
